// File: rtl/num_feeder_pkg.sv
// num_feeder_pkg: shared state encoding, default parameters and a helper.
// Latency: n/a (no logic).
// Backpressure: n/a.
package num_feeder_pkg;

  localparam int DEF_WIDTH       = 4;
  localparam int DEF_HOLD_CYCLES = 2;
  localparam int DEF_GAP_CYCLES  = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/num_feeder_if.sv
// num_feeder_if: control inputs and sample outputs of num_feeder.
// Latency: n/a (wires only).
// Backpressure: none; enable is a capture strobe, not a handshake.
// Ports: start/stop/load/load_val/step (and dir when NUM_FEEDER_DOWN_EN is
// defined) driven by the master; numout/enable/busy/wrapped driven by the slave.
interface num_feeder_if #(
  parameter int WIDTH = num_feeder_pkg::DEF_WIDTH
) ();

  logic             start;
  logic             stop;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] step;
`ifdef NUM_FEEDER_DOWN_EN
  logic             dir;
`endif
  logic [WIDTH-1:0] numout;
  logic             enable;
  logic             busy;
  logic             wrapped;

`ifdef NUM_FEEDER_DOWN_EN
  modport master (output start, stop, load, load_val, step, dir,
                  input  numout, enable, busy, wrapped);
  modport slave  (input  start, stop, load, load_val, step, dir,
                  output numout, enable, busy, wrapped);
`else
  modport master (output start, stop, load, load_val, step,
                  input  numout, enable, busy, wrapped);
  modport slave  (input  start, stop, load, load_val, step,
                  output numout, enable, busy, wrapped);
`endif

endinterface

// File: rtl/num_feeder_timer.sv
// feeder_timer: loadable down-counter with terminal-count flag, shared by HOLD and GAP.
// Latency: load takes effect on the next edge; o_tc is decoded from the count register.
// Backpressure: none.
// Ports: clk, rst_n, i_load/i_load_val (reload), o_tc (count is zero).
module feeder_timer #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  output logic          o_tc
);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/num_feeder.sv
// num_feeder: streams numout to a shift stage, enable high HOLD_CYCLES then low GAP_CYCLES per sample.
// Latency: start sampled in IDLE -> first HOLD cycle after the next edge; all outputs registered.
// Backpressure: none; stop ends streaming at the next sample boundary (end of HOLD, or at once in GAP).
// Ports: clk, rst_n (async active-low), bus (num_feeder_if.slave).
// Optional: define NUM_FEEDER_DOWN_EN to add bus.dir (1 = count down by step, borrow pulses wrapped).
module num_feeder
  import num_feeder_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int GAP_CYCLES  = DEF_GAP_CYCLES
) (
  input  logic         clk,
  input  logic         rst_n,
  num_feeder_if.slave  bus
);

  localparam int            CW      = $clog2(max2(HOLD_CYCLES, GAP_CYCLES) + 1);
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CYCLES - 1);

  state_t           r_state;
  state_t           w_next;
  logic             r_stop;
  logic [WIDTH-1:0] r_numout;
  logic             r_enable;
  logic             r_busy;
  logic             r_wrapped;

  logic             w_tmr_load;
  logic [CW-1:0]    w_tmr_val;
  logic             w_tmr_tc;
  logic             w_advance;
  logic             w_load_num;
  logic             w_stop_any;
  logic [WIDTH:0]   w_sum;

  feeder_timer #(.CW(CW)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_tc       (w_tmr_tc)
  );

  // A stop in the final HOLD cycle counts as well as an earlier latched one.
  assign w_stop_any = r_stop | bus.stop;

  // Extra MSB carries the carry (up) or borrow (down) out of the WIDTH-bit result.
`ifdef NUM_FEEDER_DOWN_EN
  always_comb begin
    w_sum = {1'b0, r_numout} + {1'b0, bus.step};
    if (bus.dir) begin
      w_sum = {1'b0, r_numout} - {1'b0, bus.step};
    end
  end
`else
  assign w_sum = {1'b0, r_numout} + {1'b0, bus.step};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_tmr_load = 1'b0;
    w_tmr_val  = HOLD_LD;
    w_advance  = 1'b0;
    w_load_num = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_load_num = bus.load;
        if (bus.start && !bus.stop) begin
          w_next     = ST_HOLD;
          w_tmr_load = 1'b1;
          w_tmr_val  = HOLD_LD;
        end
      end
      ST_HOLD: begin
        if (w_tmr_tc) begin
          if (w_stop_any) begin
            w_next = ST_IDLE;
          end else begin
            w_next     = ST_GAP;
            w_tmr_load = 1'b1;
            w_tmr_val  = GAP_LD;
          end
        end
      end
      ST_GAP: begin
        if (bus.stop) begin
          w_next = ST_IDLE;
        end else if (w_tmr_tc) begin
          w_next     = ST_HOLD;
          w_tmr_load = 1'b1;
          w_tmr_val  = HOLD_LD;
          w_advance  = 1'b1;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next-state decode so they line up with r_state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stop    <= 1'b0;
      r_numout  <= '0;
      r_enable  <= 1'b0;
      r_busy    <= 1'b0;
      r_wrapped <= 1'b0;
    end else begin
      // Stop latch lives only while HOLD continues; it clears on any exit.
      r_stop    <= (r_state == ST_HOLD) && (w_next == ST_HOLD) && w_stop_any;
      r_enable  <= (w_next == ST_HOLD);
      r_busy    <= (w_next != ST_IDLE);
      r_wrapped <= w_advance & w_sum[WIDTH];
      if (w_load_num) begin
        r_numout <= bus.load_val;
      end else if (w_advance) begin
        r_numout <= w_sum[WIDTH-1:0];
      end
    end
  end

  assign bus.numout  = r_numout;
  assign bus.enable  = r_enable;
  assign bus.busy    = r_busy;
  assign bus.wrapped = r_wrapped;

endmodule
